// File: rtl/coord_snapshot_fetch_pkg.sv
// Shared definitions for the coordinate snapshot fetcher: coordinate word
// addresses, FSM encoding and the read tag carried alongside RAM reads.
package bananachine_pkg;

    localparam int unsigned NUM_COORDS = 6;
    localparam int unsigned IDX_W      = 3;

    // Word addresses in fetch order: mx, my, p1x, p1y, p2x, p2y
    localparam int unsigned COORD_ADDR [NUM_COORDS] = '{6000, 6004, 6008, 6012, 6016, 6020};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/coord_snapshot_fetch_if.sv
// RAM port A as seen by the snapshot fetcher: read-only address/data pair.
interface coord_snapshot_fetch_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic [WIDTH-1:0] vga_address;
    logic [WIDTH-1:0] data_from_mem_vga;
    logic             we_a;

    modport master (
        output vga_address,
        output we_a,
        input  data_from_mem_vga
    );

    modport slave (
        input  vga_address,
        input  we_a,
        output data_from_mem_vga
    );

endinterface

// File: rtl/coord_snapshot_fetch_tagpipe.sv
// MEM_LATENCY-deep shift of {valid, index} that lines each issued read up
// with the cycle its data is present on q_a.
module read_tag_pipe
    import bananachine_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/coord_snapshot_fetch.sv
// Per-frame burst read of six coordinate words into shadow registers, then an
// atomic commit so the renderer never sees a half-updated frame.
module coord_snapshot_fetch
    import bananachine_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned MXP         = COORD_ADDR[0],
    parameter int unsigned MYP         = COORD_ADDR[1],
    parameter int unsigned P1XP        = COORD_ADDR[2],
    parameter int unsigned P1YP        = COORD_ADDR[3],
    parameter int unsigned P2XP        = COORD_ADDR[4],
    parameter int unsigned P2YP        = COORD_ADDR[5]
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   frame_start,
    coord_snapshot_fetch_if.master mem,
    output logic [WIDTH-1:0]       mx,
    output logic [WIDTH-1:0]       my,
    output logic [WIDTH-1:0]       p1x,
    output logic [WIDTH-1:0]       p1y,
    output logic [WIDTH-1:0]       p2x,
    output logic [WIDTH-1:0]       p2y,
    output logic                   busy,
    output logic                   snapshot_valid,
    output logic                   overrun
);

    localparam logic [WIDTH-1:0] ADDR_TBL [NUM_COORDS] = '{
        WIDTH'(MXP), WIDTH'(MYP), WIDTH'(P1XP), WIDTH'(P1YP), WIDTH'(P2XP), WIDTH'(P2YP)
    };
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COORDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] issue_idx_q, issue_idx_d, next_idx;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             busy_q, busy_d;
    logic             valid_q;
    logic             overrun_q, overrun_d;
    logic             fs_q;
    logic             last_cap_q;
    logic             commit;
    logic [WIDTH-1:0] shadow_q [NUM_COORDS];
    logic [WIDTH-1:0] coord_q  [NUM_COORDS];
    tag_t             tag_in, tag_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_idx_d = issue_idx_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        commit      = 1'b0;
        next_idx    = issue_idx_q + IDX_W'(1);

        // Only a fresh rising edge counts as a colliding start; a held level
        // is simply re-accepted once the FSM is back in IDLE.
        if (state_q != IDLE && frame_start && !fs_q) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d     = ISSUE;
                    busy_d      = 1'b1;
                    issue_idx_d = '0;
                    addr_d      = ADDR_TBL[0];
                end
            end
            ISSUE: begin
                if (issue_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    issue_idx_d = next_idx;
                    addr_d      = ADDR_TBL[next_idx];
                end
            end
            DRAIN: begin
                if (last_cap_q) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d     = IDLE;
                busy_d      = 1'b0;
                commit      = 1'b1;
                issue_idx_d = '0;
                addr_d      = ADDR_TBL[0];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = (state_q == ISSUE);
        tag_in.idx   = issue_idx_q;
    end

    read_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_idx_q <= '0;
            addr_q      <= ADDR_TBL[0];
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            fs_q        <= 1'b0;
            last_cap_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_COORDS; i++) begin
                shadow_q[i] <= '0;
                coord_q[i]  <= '0;
            end
        end else begin
            issue_idx_q <= issue_idx_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            valid_q     <= commit;
            overrun_q   <= overrun_d;
            fs_q        <= frame_start;
            last_cap_q  <= tag_out.valid && (tag_out.idx == LAST_IDX);
            if (tag_out.valid) begin
                shadow_q[tag_out.idx] <= mem.data_from_mem_vga;
            end
            if (commit) begin
                for (int unsigned i = 0; i < NUM_COORDS; i++) begin
                    coord_q[i] <= shadow_q[i];
                end
            end
        end
    end

    assign mem.vga_address = addr_q;
    assign mem.we_a        = 1'b0;

    assign mx             = coord_q[0];
    assign my             = coord_q[1];
    assign p1x            = coord_q[2];
    assign p1y            = coord_q[3];
    assign p2x            = coord_q[4];
    assign p2y            = coord_q[5];
    assign busy           = busy_q;
    assign snapshot_valid = valid_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_coord_snapshot_fetch.sv
// Directed bench: a latency-1 and a latency-3 fetcher share one RAM image.
module tb_coord_snapshot_fetch;

    logic        clk;
    logic        rst_n;
    logic        fs;
    logic [15:0] ram [0:65535];
    logic [15:0] c1 [6];
    logic [15:0] c3 [6];
    logic        busy1, valid1, ovr1;
    logic        busy3, valid3, ovr3;
    logic [15:0] a1, a2;
    int          checks;
    int          errors;

    coord_snapshot_fetch_if #(.WIDTH(16)) bus1 ();
    coord_snapshot_fetch_if #(.WIDTH(16)) bus3 ();

    coord_snapshot_fetch #(.WIDTH(16), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .reset(rst_n), .frame_start(fs), .mem(bus1),
        .mx(c1[0]), .my(c1[1]), .p1x(c1[2]), .p1y(c1[3]), .p2x(c1[4]), .p2y(c1[5]),
        .busy(busy1), .snapshot_valid(valid1), .overrun(ovr1)
    );

    coord_snapshot_fetch #(.WIDTH(16), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst_n), .frame_start(fs), .mem(bus3),
        .mx(c3[0]), .my(c3[1]), .p1x(c3[2]), .p1y(c3[3]), .p2x(c3[4]), .p2y(c3[5]),
        .busy(busy3), .snapshot_valid(valid3), .overrun(ovr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port A models: one-cycle and three-cycle read latency
    always @(posedge clk) bus1.data_from_mem_vga <= ram[bus1.vga_address];
    always @(posedge clk) begin
        a1 <= bus3.vga_address;
        a2 <= a1;
        bus3.data_from_mem_vga <= ram[a2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp1 [6];
        int          pulses;
        int          pulse_edge;
        int          bad_addr;
        int          edge_a;
        int          edge_b;
        logic [15:0] mx_at9;

        checks = 0;
        errors = 0;
        exp1   = '{16'd100, 16'd200, 16'd10, 16'd440, 16'd620, 16'd440};
        for (int i = 0; i < 65536; i++) ram[i] = '0;
        ram[6000] = 16'd100; ram[6004] = 16'd200; ram[6008] = 16'd10;
        ram[6012] = 16'd440; ram[6016] = 16'd620; ram[6020] = 16'd440;

        fs    = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        for (int i = 0; i < 6; i++) chk("reset_coord", c1[i], 0);
        chk("reset_busy", busy1, 0);
        chk("reset_valid", valid1, 0);
        chk("reset_overrun", ovr1, 0);
        chk("reset_addr", bus1.vga_address, 6000);
        chk("reset_we_a", bus1.we_a, 0);

        // Scenario 1: basic fetch, both latencies
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("s1_busy_after_e0", busy1, 1);
        for (int c = 0; c < 6; c++) begin
            chk("s1_addr_seq", bus1.vga_address, 32'(6000 + 4 * c));
            chk("s1_no_early_valid", valid1, 0);
            tick();
        end
        chk("s1_addr_hold_p2yp", bus1.vga_address, 6020);
        tick();
        chk("s1_valid_e7", valid1, 0);
        tick();
        chk("s1_valid_e8", valid1, 0);
        chk("s1_busy_e8", busy1, 1);
        chk("s1_mx_unchanged_e8", c1[0], 0);
        tick();
        chk("s1_valid_e9", valid1, 1);
        chk("s1_busy_e9", busy1, 0);
        chk("s1_addr_idle", bus1.vga_address, 6000);
        for (int i = 0; i < 6; i++) chk("s1_coord", c1[i], 32'(exp1[i]));
        chk("s1_l3_valid_e9", valid3, 0);
        tick();
        chk("s1_valid_e10", valid1, 0);
        chk("s1_l3_valid_e10", valid3, 0);
        tick();
        chk("s1_l3_valid_e11", valid3, 1);
        for (int i = 0; i < 6; i++) chk("s1_l3_coord", c3[i], 32'(exp1[i]));
        tick();
        chk("s1_l3_valid_e12", valid3, 0);

        // Scenario 2: port B write after index 0 was read
        fs = 1'b1;
        tick();
        fs = 1'b0;
        tick();
        tick();
        ram[6000] = 16'd555;
        for (int e = 3; e <= 8; e++) begin
            tick();
            chk("s2_valid_before", valid1, 0);
        end
        tick();
        chk("s2_valid_e9", valid1, 1);
        chk("s2_mx_old", c1[0], 100);
        tick();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("s2b_mx_stable", c1[0], 100);
            chk("s2b_valid_before", valid1, 0);
        end
        tick();
        chk("s2b_valid_e9", valid1, 1);
        chk("s2b_mx_new", c1[0], 555);
        chk("s2b_my", c1[1], 200);
        chk("s2b_p2y", c1[5], 440);
        repeat (3) tick();

        // Scenario 3: second pulse mid-fetch
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (3) tick();
        fs = 1'b1;
        tick();
        fs = 1'b0;
        chk("s3_overrun_set", ovr1, 1);
        chk("s3_busy", busy1, 1);
        pulses     = 0;
        pulse_edge = -1;
        bad_addr   = 0;
        for (int e = 5; e <= 30; e++) begin
            tick();
            if (valid1) begin
                pulses++;
                pulse_edge = e;
            end
            if (e > 9 && bus1.vga_address != 16'd6000) bad_addr++;
        end
        chk("s3_pulse_count", pulses, 1);
        chk("s3_pulse_edge", pulse_edge, 9);
        chk("s3_no_restart_addr", bad_addr, 0);
        chk("s3_overrun_sticky", ovr1, 1);
        chk("s3_busy_done", busy1, 0);

        // Scenario 4: reset in the middle of a fetch
        fs = 1'b1;
        tick();
        fs = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) chk("s4_coord_zero", c1[i], 0);
        chk("s4_busy", busy1, 0);
        chk("s4_addr", bus1.vga_address, 6000);
        chk("s4_overrun_clear", ovr1, 0);
        chk("s4_valid", valid1, 0);
        pulses = 0;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (valid1 || valid3) pulses++;
        end
        chk("s4_no_pulse", pulses, 0);
        chk("s4_busy_stays_low", busy1, 0);
        chk("s4_l3_mx_zero", c3[0], 0);

        // Scenario 6: frame_start held high for 20 edges
        fs     = 1'b1;
        pulses = 0;
        edge_a = -1;
        edge_b = -1;
        mx_at9 = '0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (valid1) begin
                pulses++;
                if (edge_a < 0) edge_a = e;
                else edge_b = e;
            end
            if (e == 9) mx_at9 = c1[0];
        end
        fs = 1'b0;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (valid1) pulses++;
        end
        chk("s6_pulse_count", pulses, 2);
        chk("s6_first_edge", edge_a, 9);
        chk("s6_second_edge", edge_b, 19);
        chk("s6_mx_at9", mx_at9, 555);
        chk("s6_overrun", ovr1, 0);
        chk("s6_busy_done", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
